// File: rtl/alu_unit_if.sv
// Operand/result bundle for alu_unit. The master drives the operands and the
// opcode. The slave (the ALU) returns the registered result and the flag.
interface alu_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] out;
    logic             overflow;

    modport master (
        output in0, in1, opcode,
        input  out, overflow
    );

    modport slave (
        input  in0, in1, opcode,
        output out, overflow
    );
endinterface

// File: rtl/alu_unit.sv
// Registered unsigned ALU with one cycle of latency.
// An 8-entry opcode map selects the operation. The result and the
// carry/borrow/shift-out flag are captured together on every rising edge.
module alu_unit #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    alu_unit_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // One extra bit: its MSB is the carry for ADD and the borrow for SUB.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] result;
    logic             flag;

    // Next result and flag, computed from the current operands.
    always_comb begin
        sum_ext  = {1'b0, bus.in0} + {1'b0, bus.in1};
        diff_ext = {1'b0, bus.in0} - {1'b0, bus.in1};
        result   = '0;
        flag     = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                result = sum_ext[WIDTH-1:0];
                flag   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                result = diff_ext[WIDTH-1:0];
                flag   = diff_ext[WIDTH];
            end
            OP_AND: result = bus.in0 & bus.in1;
            OP_OR:  result = bus.in0 | bus.in1;
            OP_XOR: result = bus.in0 ^ bus.in1;
            OP_NOT: result = ~bus.in0;
            OP_SHL: begin
                result = {bus.in0[WIDTH-2:0], 1'b0};
                flag   = bus.in0[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, bus.in0[WIDTH-1:1]};
                flag   = bus.in0[0];
            end
            default: begin
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end

    // Output register. Reset wins over computation. The flag is reloaded every
    // cycle alongside the result, so it never holds a stale value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out      <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.out      <= result;
            bus.overflow <= flag;
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit at WIDTH = 16.
// Directed steps come from the design's intended behaviour. They are followed
// by random operands that are checked against an arithmetic reference model.
module tb_alu_unit;
    localparam int WIDTH = 16;
    localparam int MODV  = 65536;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned values.
    // It returns the flag in bit 16 and the result in bits 15:0.
    function automatic int model(input int a, input int b, input int op);
        int r;
        int f;
        r = 0;
        f = 0;
        case (op)
            0: begin r = (a + b) % MODV; f = (a + b >= MODV) ? 1 : 0; end
            1: begin r = (a - b + MODV) % MODV; f = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (MODV - 1) - a;
            6: begin r = (a * 2) % MODV; f = a / (MODV / 2); end
            7: begin r = a / 2; f = a % 2; end
            default: r = 0;
        endcase
        return (f << 16) | r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int op, input logic r);
        bus.in0    = a[15:0];
        bus.in1    = b[15:0];
        bus.opcode = op[2:0];
        rst        = r;
    endtask

    // Apply the inputs, take one rising edge, then compare shortly after it.
    task automatic step_check(input string tag, input int a, input int b, input int op,
                              input logic r, input int exp_out, input int exp_ov);
        drive(a, b, op, r);
        @(posedge clk);
        #1;
        check({tag, ".out"}, {16'h0, bus.out}, exp_out);
        check({tag, ".ov"}, {31'h0, bus.overflow}, exp_ov);
    endtask

    initial begin
        int sweep_exp [8];
        int a, b, op, m;
        logic r;

        sweep_exp = '{24, 16, 4, 20, 16, 'hFFEB, 40, 10};
        drive(0, 0, 0, 1'b0);
        @(posedge clk);
        #1;

        // Reset takes priority over a live ADD and holds while rst stays high.
        step_check("reset", 'h1234, 'h5678, 0, 1'b1, 0, 0);
        step_check("reset_hold", 'h1234, 'h5678, 0, 1'b1, 0, 0);
        // The first edge after reset is released loads a real result.
        step_check("reset_release", 'h1234, 'h5678, 0, 1'b0, 'h68AC, 0);

        // Opcode sweep, one opcode per cycle.
        for (int i = 0; i < 8; i++)
            step_check($sformatf("sweep_op%0d", i), 20, 4, i, 1'b0, sweep_exp[i], 0);

        step_check("add_wrap", 'hFFFF, 1, 0, 1'b0, 0, 1);
        step_check("sub_borrow", 4, 20, 1, 1'b0, 'hFFF0, 1);
        step_check("sub_equal", 7, 7, 1, 1'b0, 0, 0);
        step_check("shl_out", 'h8001, 0, 6, 1'b0, 'h0002, 1);
        step_check("shr_out", 'h8001, 0, 7, 1'b0, 'h4000, 1);
        step_check("not_zero", 0, 'hABCD, 5, 1'b0, 'hFFFF, 0);

        // The flag is not sticky: an ADD carry is followed by a flag-free AND.
        step_check("carry_set", 'hFFFF, 'hFFFF, 0, 1'b0, 'hFFFE, 1);
        step_check("carry_clear", 'hFFFF, 'hFFFF, 2, 1'b0, 'hFFFF, 0);

        // Reset in the middle of a running ADD.
        step_check("mid_add", 20, 4, 0, 1'b0, 24, 0);
        step_check("mid_rst", 20, 4, 0, 1'b1, 0, 0);
        step_check("mid_resume", 20, 4, 0, 1'b0, 24, 0);

        // A pulse on rst or an input glitch between edges must not change the outputs.
        rst = 1'b1;
        bus.in0 = 16'h0F0F;
        bus.opcode = 3'b101;
        #2;
        rst = 1'b0;
        bus.in0 = 16'd20;
        bus.opcode = 3'b000;
        #1;
        check("glitch.out", {16'h0, bus.out}, 24);
        check("glitch.ov", {31'h0, bus.overflow}, 0);

        // Random operands and opcodes, with occasional reset edges.
        for (int i = 0; i < 400; i++) begin
            a  = int'($urandom_range(0, MODV - 1));
            b  = int'($urandom_range(0, MODV - 1));
            op = int'($urandom_range(0, 7));
            r  = ($urandom_range(0, 19) == 0);
            // Corner operands come up often enough to exercise the carry and shift-out paths.
            if ($urandom_range(0, 7) == 0) a = MODV - 1;
            if ($urandom_range(0, 7) == 0) b = a;
            m = r ? 0 : model(a, b, op);
            step_check($sformatf("rand%0d_op%0d", i, op), a, b, op, r, m & 'hFFFF, (m >> 16) & 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit so that the run always ends, even if clocking goes wrong.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
